// File: rtl/interboard_link_if.sv
// interboard_link_if: one direction of the 4-phase req/ack board link
interface interboard_link_if;
   logic       req;
   logic [7:0] data;
   logic       ack;
   modport master (output req, output data, input ack);
   modport slave  (input req, input data, output ack);
endinterface

// File: rtl/interboard_link.sv
// interboard_link: carries 8-bit {type, number} frames between boards over 4-phase req/ack
module interboard_link #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_ctrl_en,
   input  logic [2:0]        i_ctrl_msg_type,
   input  logic [4:0]        i_ctrl_number,
   output logic              o_inter_ready,
   output logic              o_tx_busy,
   output logic              o_tx_timeout,
   output logic              o_tx_overrun,
   output logic              o_interboard_en,
   output logic [2:0]        o_interboard_msg_type,
   output logic [4:0]        o_interboard_number,
   interboard_link_if.master o_tx,
   interboard_link_if.slave  i_rx
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {T_IDLE, T_SETUP, T_REQ, T_ACK_LOW, T_ABORT} tx_state_t;
   typedef enum logic {R_IDLE, R_REQ_LOW} rx_state_t;

   logic [1:0]             r_rst_sync;
   logic                   w_rst_n;
   logic [SYNC_STAGES-1:0] r_ack_sync;
   logic [SYNC_STAGES-1:0] r_req_sync;
   logic                   w_ack;
   logic                   w_req;
   tx_state_t              r_tx_state;
   tx_state_t              w_tx_next;
   logic [CW-1:0]          r_cnt;
   logic                   w_cnt_done;
   logic                   w_load;
   logic                   w_ready;
   logic                   w_timeout;
   logic                   r_tx_req;
   logic [7:0]             r_tx_data;
   logic                   r_inter_ready;
   logic                   r_tx_timeout;
   rx_state_t              r_rx_state;
   rx_state_t              w_rx_next;
   logic                   w_capture;
   logic                   r_rx_ack;
   logic                   r_ib_en;
   logic [7:0]             r_ib_data;

   // reset asserts immediately but releases only on a clock edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_rst_sync <= '0;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};

   assign w_rst_n = r_rst_sync[1];

   // bring the peer's asynchronous ack and req into the local clock domain
   always_ff @(posedge clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_ack_sync <= '0;
         r_req_sync <= '0;
      end else begin
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], o_tx.ack};
         r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], i_rx.req};
      end

   assign w_ack      = r_ack_sync[SYNC_STAGES-1];
   assign w_req      = r_req_sync[SYNC_STAGES-1];
   assign w_cnt_done = (r_cnt == CNT_LAST);

   // TX next state: send one frame, wait for ack rise then fall, abort if ack never comes
   always_comb begin
      w_tx_next = r_tx_state;
      w_load    = 1'b0;
      w_ready   = 1'b0;
      w_timeout = 1'b0;
      case (r_tx_state)
         T_IDLE:    if (i_ctrl_en) begin
                       w_tx_next = T_SETUP;
                       w_load    = 1'b1;
                    end
         T_SETUP:   w_tx_next = T_REQ;
         T_REQ:     if (w_ack) w_tx_next = T_ACK_LOW;
                    else if (w_cnt_done) begin
                       w_tx_next = T_ABORT;
                       w_timeout = 1'b1;
                    end
         T_ACK_LOW: if (!w_ack) begin
                       w_tx_next = T_IDLE;
                       w_ready   = 1'b1;
                    end
         T_ABORT:   if (!w_ack) w_tx_next = T_IDLE;
         default:   w_tx_next = T_IDLE;
      endcase
   end

   // TX state and registered outputs; req is decoded from the next state so it is glitch-free
   always_ff @(posedge clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_tx_state    <= T_IDLE;
         r_tx_req      <= 1'b0;
         r_tx_data     <= '0;
         r_inter_ready <= 1'b0;
         r_tx_timeout  <= 1'b0;
      end else begin
         r_tx_state    <= w_tx_next;
         r_tx_req      <= (w_tx_next == T_REQ);
         r_inter_ready <= w_ready;
         r_tx_timeout  <= w_timeout;
         if (w_load) r_tx_data <= {i_ctrl_msg_type, i_ctrl_number};
      end

   // timeout counter: held at zero outside T_REQ, saturates at its last value
   always_ff @(posedge clk or negedge w_rst_n)
      if (!w_rst_n)                 r_cnt <= '0;
      else if (r_tx_state != T_REQ) r_cnt <= '0;
      else if (!w_cnt_done)         r_cnt <= r_cnt + CW'(1);

   // RX next state: one capture per peer req rise, then wait for req to fall
   always_comb begin
      w_rx_next = r_rx_state;
      w_capture = 1'b0;
      case (r_rx_state)
         R_IDLE:    if (w_req) begin
                       w_rx_next = R_REQ_LOW;
                       w_capture = 1'b1;
                    end
         R_REQ_LOW: if (!w_req) w_rx_next = R_IDLE;
         default:   w_rx_next = R_IDLE;
      endcase
   end

   // RX state, ack and captured frame all update on the same edge
   always_ff @(posedge clk or negedge w_rst_n)
      if (!w_rst_n) begin
         r_rx_state <= R_IDLE;
         r_rx_ack   <= 1'b0;
         r_ib_en    <= 1'b0;
         r_ib_data  <= '0;
      end else begin
         r_rx_state <= w_rx_next;
         r_rx_ack   <= (w_rx_next == R_REQ_LOW);
         r_ib_en    <= w_capture;
         if (w_capture) r_ib_data <= i_rx.data;
      end

   assign o_tx.req              = r_tx_req;
   assign o_tx.data             = r_tx_data;
   assign i_rx.ack              = r_rx_ack;
   assign o_inter_ready         = r_inter_ready;
   assign o_tx_busy             = (r_tx_state != T_IDLE);
   assign o_tx_timeout          = r_tx_timeout;
   assign o_tx_overrun          = i_ctrl_en && o_tx_busy;
   assign o_interboard_en       = r_ib_en;
   assign o_interboard_msg_type = r_ib_data[7:5];
   assign o_interboard_number   = r_ib_data[4:0];
endmodule

// File: tb/tb_interboard_link.sv
// tb_interboard_link: loopback A->B plus bench-driven peers on A.rx and B.tx
module tb_interboard_link;
   logic       clk = 1'b0;
   logic       rst_n_a, rst_n_b;
   logic       a_en, b_en;
   logic [2:0] a_type, b_type;
   logic [4:0] a_num, b_num;
   logic       a_ready, a_busy, a_to, a_ov, a_ien;
   logic       b_ready, b_busy, b_to, b_ov, b_ien;
   logic [2:0] a_itype, b_itype;
   logic [4:0] a_inum, b_inum;
   int         vectors = 0;
   int         errors  = 0;

   interboard_link_if ab ();
   interboard_link_if pa ();
   interboard_link_if pb ();

   always #5 clk = ~clk;

   interboard_link u_a (
      .clk(clk), .rst_n(rst_n_a), .i_ctrl_en(a_en), .i_ctrl_msg_type(a_type), .i_ctrl_number(a_num),
      .o_inter_ready(a_ready), .o_tx_busy(a_busy), .o_tx_timeout(a_to), .o_tx_overrun(a_ov),
      .o_interboard_en(a_ien), .o_interboard_msg_type(a_itype), .o_interboard_number(a_inum),
      .o_tx(ab), .i_rx(pa)
   );

   interboard_link #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) u_b (
      .clk(clk), .rst_n(rst_n_b), .i_ctrl_en(b_en), .i_ctrl_msg_type(b_type), .i_ctrl_number(b_num),
      .o_inter_ready(b_ready), .o_tx_busy(b_busy), .o_tx_timeout(b_to), .o_tx_overrun(b_ov),
      .o_interboard_en(b_ien), .o_interboard_msg_type(b_itype), .o_interboard_number(b_inum),
      .o_tx(pb), .i_rx(ab)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [22:0] oa, ob;
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      a_en = 1'b0; a_type = '0; a_num = '0;
      b_en = 1'b0; b_type = '0; b_num = '0;
      pa.req = 1'b0; pa.data = '0; pb.ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         oa = {a_ready, a_busy, a_to, a_ov, a_ien, a_itype, a_inum, ab.req, ab.data, pa.ack};
         ob = {b_ready, b_busy, b_to, b_ov, b_ien, b_itype, b_inum, pb.req, pb.data, ab.ack};
         vectors++;
         if (oa !== 23'd0) begin errors++; $display("FAIL reset_a[%0d] got %h want 0", i, oa); end
         vectors++;
         if (ob !== 23'd0) begin errors++; $display("FAIL reset_b[%0d] got %h want 0", i, ob); end
         rst_n_a = 1'b1; rst_n_b = 1'b1;
         repeat (4) tick();
      end
   endtask

   task automatic test_loopback();
      logic [6:0] obs, exp;
      tick();
      a_type = 3'd2; a_num = 5'd17; a_en = 1'b1;
      for (int k = 0; k < 23; k++) begin
         if (k == 1) a_en = 1'b0;
         @(negedge clk);
         obs = {ab.req, a_busy, a_ready, a_to, a_ov, b_ien, ab.ack};
         exp = {k >= 2 && k < 8, k >= 1 && k < 14, k == 14, 1'b0, 1'b0, k == 5, k >= 5 && k < 11};
         vectors++;
         if (obs !== exp) begin errors++; $display("FAIL loopback_k%0d {req,busy,rdy,to,ov,ien,ack} got %b want %b", k, obs, exp); end
         if (k >= 1) begin
            vectors++;
            if (ab.data !== 8'h51) begin errors++; $display("FAIL loopback_data_k%0d got %h want 51", k, ab.data); end
         end
         if (k >= 5) begin
            vectors++;
            if ({b_itype, b_inum} !== {3'd2, 5'd17}) begin errors++; $display("FAIL loopback_rx_k%0d got %0d/%0d want 2/17", k, b_itype, b_inum); end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] frames [3];
      logic [7:0] q[$];
      logic [7:0] e;
      int sent, got, rdy;
      frames[0] = 8'h25; frames[1] = 8'h00; frames[2] = 8'hFF;
      sent = 0; got = 0; rdy = 0;
      tick();
      {a_type, a_num} = frames[0]; a_en = 1'b1; q.push_back(frames[0]); sent = 1;
      for (int k = 0; k < 60; k++) begin
         if (k > 0) begin
            a_en = 1'b0;
            if (a_ready && sent < 3) begin
               {a_type, a_num} = frames[sent]; a_en = 1'b1; q.push_back(frames[sent]); sent++;
            end
         end
         @(negedge clk);
         if (a_ready) rdy++;
         if (b_ien) begin
            got++;
            e = 8'hxx;
            if (q.size() != 0) e = q.pop_front();
            vectors++;
            if ({b_itype, b_inum} !== e) begin errors++; $display("FAIL b2b_frame%0d got %h want %h", got, {b_itype, b_inum}, e); end
         end
         tick();
      end
      a_en = 1'b0;
      vectors++;
      if (got !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got); end
      vectors++;
      if (rdy !== 3) begin errors++; $display("FAIL b2b_ready got %0d want 3", rdy); end
   endtask

   task automatic test_overrun();
      logic [7:0] x, y;
      int got, rdy;
      x = 8'($urandom); y = 8'($urandom); got = 0; rdy = 0;
      tick();
      {a_type, a_num} = x; a_en = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (k == 1) a_en = 1'b0;
         if (k == 4) begin {a_type, a_num} = y; a_en = 1'b1; end
         if (k == 5) a_en = 1'b0;
         @(negedge clk);
         vectors++;
         if (a_ov !== (k == 4)) begin errors++; $display("FAIL overrun_k%0d got %b want %b", k, a_ov, k == 4); end
         if (a_ready) rdy++;
         if (b_ien) begin
            got++;
            vectors++;
            if ({b_itype, b_inum} !== x) begin errors++; $display("FAIL overrun_frame got %h want %h", {b_itype, b_inum}, x); end
         end
         tick();
      end
      vectors++;
      if (got !== 1) begin errors++; $display("FAIL overrun_count got %0d want 1", got); end
      vectors++;
      if (rdy !== 1) begin errors++; $display("FAIL overrun_ready got %0d want 1", rdy); end
   endtask

   task automatic test_timeout();
      logic [7:0] x;
      logic [3:0] obs, exp;
      x = 8'($urandom);
      pb.ack = 1'b0;
      tick();
      {b_type, b_num} = x; b_en = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (k == 1) b_en = 1'b0;
         @(negedge clk);
         obs = {pb.req, b_to, b_ready, b_ov};
         exp = {k >= 2 && k < 18, k == 18, 1'b0, 1'b0};
         vectors++;
         if (obs !== exp) begin errors++; $display("FAIL timeout_k%0d {req,to,rdy,ov} got %b want %b", k, obs, exp); end
         if (k == 10) begin
            vectors++;
            if (pb.data !== x) begin errors++; $display("FAIL timeout_data got %h want %h", pb.data, x); end
         end
         if (k == 25) begin
            vectors++;
            if (b_busy !== 1'b0) begin errors++; $display("FAIL timeout_idle busy got %b want 0", b_busy); end
         end
         tick();
      end
   endtask

   task automatic test_rx_hold();
      logic [7:0] d;
      logic [1:0] obs, exp;
      d = 8'($urandom);
      tick();
      pa.data = d; pa.req = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if (k == 10) pa.data = ~d;
         if (k == 50) pa.req = 1'b0;
         @(negedge clk);
         obs = {a_ien, pa.ack};
         exp = {k == 3, k >= 3 && k < 53};
         vectors++;
         if (obs !== exp) begin errors++; $display("FAIL rxhold_k%0d {ien,ack} got %b want %b", k, obs, exp); end
         if (k == 59) begin
            vectors++;
            if ({a_itype, a_inum} !== d) begin errors++; $display("FAIL rxhold_data got %h want %h", {a_itype, a_inum}, d); end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] x, y;
      logic [22:0] oa;
      int got, rdy;
      x = 8'($urandom); y = 8'($urandom); got = 0; rdy = 0;
      tick();
      {a_type, a_num} = x; a_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k == 1) a_en = 1'b0;
         if (k == 6) begin
            rst_n_a = 1'b0;
            #1;
            oa = {a_ready, a_busy, a_to, a_ov, a_ien, a_itype, a_inum, ab.req, ab.data, pa.ack};
            vectors++;
            if (oa !== 23'd0) begin errors++; $display("FAIL midreset_async got %h want 0", oa); end
         end
         if (k == 7) rst_n_a = 1'b1;
         @(negedge clk);
         if (a_ready) rdy++;
         if (b_ien) begin
            got++;
            vectors++;
            if ({b_itype, b_inum} !== x) begin errors++; $display("FAIL midreset_frame got %h want %h", {b_itype, b_inum}, x); end
         end
         tick();
      end
      vectors++;
      if ({got, rdy, ab.ack} !== {32'd1, 32'd0, 1'b0}) begin errors++; $display("FAIL midreset_peer got en=%0d rdy=%0d ack=%b want 1 0 0", got, rdy, ab.ack); end
      {a_type, a_num} = y; a_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k == 1) a_en = 1'b0;
         @(negedge clk);
         vectors++;
         if ({b_ien, a_ready} !== {k == 5, k == 14}) begin errors++; $display("FAIL midreset_resend_k%0d {ien,rdy} got %b want %b", k, {b_ien, a_ready}, {k == 5, k == 14}); end
         if (k == 5) begin
            vectors++;
            if ({b_itype, b_inum} !== y) begin errors++; $display("FAIL midreset_resend_data got %h want %h", {b_itype, b_inum}, y); end
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      logic [7:0] f, e;
      logic [2:0] obs, exp;
      int last;
      logic exp_ov;
      last = -1000;
      for (int k = 0; k < 400; k++) begin
         exp = {1'b0, k == last + 14, k == last + 5};
         a_en = 1'b0;
         exp_ov = 1'b0;
         if (k < 360 && $urandom_range(5) == 0) begin
            f = 8'($urandom);
            {a_type, a_num} = f; a_en = 1'b1;
            if (k >= last + 14) begin
               q.push_back(f);
               last = k;
            end else exp_ov = 1'b1;
         end
         exp[2] = exp_ov;
         @(negedge clk);
         obs = {a_ov, a_ready, b_ien};
         vectors++;
         if (obs !== exp) begin errors++; $display("FAIL random_k%0d {ov,rdy,ien} got %b want %b", k, obs, exp); end
         if (b_ien) begin
            e = 8'hxx;
            if (q.size() != 0) e = q.pop_front();
            vectors++;
            if ({b_itype, b_inum} !== e) begin errors++; $display("FAIL random_frame_k%0d got %h want %h", k, {b_itype, b_inum}, e); end
         end
         tick();
      end
      a_en = 1'b0;
      vectors++;
      if (q.size() != 0) begin errors++; $display("FAIL random_drain got %0d pending want 0", q.size()); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_back_to_back();
      test_overrun();
      test_timeout();
      test_rx_hold();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end
endmodule
